// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM memory access unit.
// Contents: transfer FSM state type, default wait-state count, wait counter width.
// No logic; imported by mem_access_unit.
package mem_pkg;

  // Transfer sequencing: one setup cycle, WAIT_CYCLES access cycles, one done cycle.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } mem_state_t;

  // Default number of SRAM access cycles per transfer.
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

  // Wait counter width; bounds WAIT_CYCLES to 1..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_access_unit.sv
// SRAM memory access unit: latches MAR/MDR on start and sequences CE_n/OE_n/WE_n
//   through SETUP, WAIT_CYCLES ACCESS cycles and DONE. Read data is captured into MDR.
// Latency: start accepted at edge t -> done high in cycle t+WAIT_CYCLES+2.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Ports: Clk, Reset (sync active-low); start/rw/addr_sel/MARMUX/PC/wdata request side;
//   Data_from_SRAM read data; busy/done status; MAR/MDR registers; ADDR, strobes,
//   Data_to_SRAM and data_drive toward the SRAM pins.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        rw,
  input  logic        addr_sel,
  input  logic [15:0] MARMUX,
  input  logic [15:0] PC,
  input  logic [15:0] wdata,
  input  logic [15:0] Data_from_SRAM,
  output logic        busy,
  output logic        done,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [19:0] ADDR,
  output logic        CE_n,
  output logic        OE_n,
  output logic        WE_n,
  output logic [15:0] Data_to_SRAM,
  output logic        data_drive
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mem_access_unit: WAIT_CYCLES=%0d outside legal range 1..15", WAIT_CYCLES);
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             rw_q;

  // Upper address bits are unused by this 16-bit core.
  assign ADDR         = {4'b0000, MAR};
  assign Data_to_SRAM = MDR;

  // Strobes are registered alongside the state transition so every output
  // is a flop; nothing from start reaches a pin without passing a register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rw_q       <= 1'b0;
      MAR        <= '0;
      MDR        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      CE_n       <= 1'b1;
      OE_n       <= 1'b1;
      WE_n       <= 1'b1;
      data_drive <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETUP;
            MAR        <= addr_sel ? PC : MARMUX;
            rw_q       <= rw;
            if (rw) MDR <= wdata;
            busy       <= 1'b1;
            CE_n       <= 1'b0;
            // Reads open the output enable from SETUP; writes drive the bus
            // from SETUP but hold WE_n off until ACCESS for address setup time.
            OE_n       <= rw;
            data_drive <= rw;
          end
        end
        S_SETUP: begin
          state <= S_ACCESS;
          cnt   <= CNT_LOAD;
          WE_n  <= ~rw_q;
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state      <= S_DONE;
            done       <= 1'b1;
            CE_n       <= 1'b1;
            OE_n       <= 1'b1;
            WE_n       <= 1'b1;
            data_drive <= 1'b0;
            if (!rw_q) MDR <= Data_from_SRAM;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed transfers push expected results,
// negedge monitors compare strobes, address, data and completion cycle.
// Three instances cover WAIT_CYCLES = 2, 1 and 15.
module tb_mem_access_unit;

  localparam int WM = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start_m, start_1, start_15;
  logic        rw, addr_sel;
  logic [15:0] MARMUX, PC, wdata, Data_from_SRAM;

  logic        busy, done, CE_n, OE_n, WE_n, data_drive;
  logic [15:0] MAR, MDR, Data_to_SRAM;
  logic [19:0] ADDR;

  logic        busy_1, done_1, ce_1, oe_1, we_1, dd_1;
  logic [15:0] mar_1, mdr_1, dts_1;
  logic [19:0] addr_1;

  logic        busy_15, done_15, ce_15, oe_15, we_15, dd_15;
  logic [15:0] mar_15, mdr_15, dts_15;
  logic [19:0] addr_15;

  always #5 Clk = ~Clk;

  mem_access_unit #(.WAIT_CYCLES(WM)) dut (
    .Clk(Clk), .Reset(Reset), .start(start_m), .rw(rw), .addr_sel(addr_sel),
    .MARMUX(MARMUX), .PC(PC), .wdata(wdata), .Data_from_SRAM(Data_from_SRAM),
    .busy(busy), .done(done), .MAR(MAR), .MDR(MDR), .ADDR(ADDR),
    .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .Data_to_SRAM(Data_to_SRAM),
    .data_drive(data_drive));

  mem_access_unit #(.WAIT_CYCLES(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .start(start_1), .rw(rw), .addr_sel(addr_sel),
    .MARMUX(MARMUX), .PC(PC), .wdata(wdata), .Data_from_SRAM(Data_from_SRAM),
    .busy(busy_1), .done(done_1), .MAR(mar_1), .MDR(mdr_1), .ADDR(addr_1),
    .CE_n(ce_1), .OE_n(oe_1), .WE_n(we_1), .Data_to_SRAM(dts_1),
    .data_drive(dd_1));

  mem_access_unit #(.WAIT_CYCLES(15)) dut_w15 (
    .Clk(Clk), .Reset(Reset), .start(start_15), .rw(rw), .addr_sel(addr_sel),
    .MARMUX(MARMUX), .PC(PC), .wdata(wdata), .Data_from_SRAM(Data_from_SRAM),
    .busy(busy_15), .done(done_15), .MAR(mar_15), .MDR(mdr_15), .ADDR(addr_15),
    .CE_n(ce_15), .OE_n(oe_15), .WE_n(we_15), .Data_to_SRAM(dts_15),
    .data_drive(dd_15));

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [15:0] data;     // expected MDR at done (write data or SRAM read data)
    int          done_cyc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_1[$];
  exp_t q_15[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int oe_cnt   = 0;
  int we_cnt   = 0;
  int dones_m  = 0;
  int dones_1  = 0;
  int dones_15 = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Main instance monitor: per-cycle strobe rules plus completion scoreboard.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset !== 1'b0) begin
      if (!busy) begin
        oe_cnt = 0;
        we_cnt = 0;
        chk("idle_outputs", {27'd0, CE_n, OE_n, WE_n, data_drive, done}, 32'b11100);
      end else begin
        chk("oe_we_exclusive", {31'd0, OE_n | WE_n}, 32'd1);
        chk("ce_vs_done", {31'd0, CE_n}, {31'd0, done});
        if (!OE_n) oe_cnt++;
        if (!WE_n) we_cnt++;
        if (q_m.size() > 0) begin
          chk("addr_stable", {12'd0, ADDR}, {16'd0, 4'h0, q_m[0].addr});
          if (data_drive) chk("drive_data", {16'd0, Data_to_SRAM}, {16'd0, q_m[0].data});
        end
        if (done) begin
          dones_m++;
          if (q_m.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done expected=none (cycle %0d)", cyc);
          end else begin
            e = q_m.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("mdr_at_done", {16'd0, MDR}, {16'd0, e.data});
            chk("oe_low_cycles", oe_cnt, e.rw ? 0 : WM + 1);
            chk("we_low_cycles", we_cnt, e.rw ? WM : 0);
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (done_1) begin
      dones_1++;
      if (q_1.size() > 0) begin
        e = q_1.pop_front();
        chk("w1_done_cycle", cyc, e.done_cyc);
        chk("w1_mdr", {16'd0, mdr_1}, {16'd0, e.data});
        chk("w1_addr", {12'd0, addr_1}, {16'd0, 4'h0, e.addr});
      end
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (done_15) begin
      dones_15++;
      if (q_15.size() > 0) begin
        e = q_15.pop_front();
        chk("w15_done_cycle", cyc, e.done_cyc);
        chk("w15_mdr", {16'd0, mdr_15}, {16'd0, e.data});
        chk("w15_addr", {12'd0, addr_15}, {16'd0, 4'h0, e.addr});
      end
    end
  end

  // One-cycle start pulse to the main instance. Drive cycle c -> done seen in cycle c+WM+2.
  task automatic issue_main(input logic r, input logic sel, input logic [15:0] mm,
                            input logic [15:0] pc_v, input logic [15:0] wd,
                            input logic [15:0] sram);
    @(negedge Clk);
    rw = r; addr_sel = sel; MARMUX = mm; PC = pc_v; wdata = wd; Data_from_SRAM = sram;
    start_m = 1'b1;
    q_m.push_back('{addr: sel ? pc_v : mm, rw: r, data: r ? wd : sram, done_cyc: cyc + WM + 2});
    @(negedge Clk);
    start_m = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; start_m = 1'b0; start_1 = 1'b0; start_15 = 1'b0;
    rw = 1'b0; addr_sel = 1'b0; MARMUX = '0; PC = '0; wdata = '0; Data_from_SRAM = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_status", {30'd0, busy, done}, 32'd0);
    chk("rst_strobes", {28'd0, CE_n, OE_n, WE_n, data_drive}, 32'b1110);
    chk("rst_mar", {16'd0, MAR}, 32'd0);
    chk("rst_mdr", {16'd0, MDR}, 32'd0);
    Reset = 1'b1;

    // Read via MARMUX; PC holds a decoy to prove the mux select.
    issue_main(1'b0, 1'b0, 16'h3000, 16'hFFFF, 16'h0000, 16'hBEEF);
    repeat (6) @(negedge Clk);
    chk("read_mar", {16'd0, MAR}, 32'h3000);

    // Write via PC; SRAM read data must not leak into MDR.
    issue_main(1'b1, 1'b1, 16'hAAAA, 16'h0200, 16'h1234, 16'hDEAD);
    repeat (6) @(negedge Clk);
    chk("write_mdr_held", {16'd0, MDR}, 32'h1234);

    // start held for 10 cycles: accepted in drive cycles c and c+5 only.
    @(negedge Clk);
    rw = 1'b0; addr_sel = 1'b0; MARMUX = 16'h1111; Data_from_SRAM = 16'h5A5A;
    start_m = 1'b1;
    q_m.push_back('{addr: 16'h1111, rw: 1'b0, data: 16'h5A5A, done_cyc: cyc + 4});
    q_m.push_back('{addr: 16'h1111, rw: 1'b0, data: 16'h5A5A, done_cyc: cyc + 9});
    repeat (10) @(negedge Clk);
    start_m = 1'b0;
    repeat (6) @(negedge Clk);

    // Abort: reset sampled at the end of the second ACCESS cycle of a read.
    @(negedge Clk);
    rw = 1'b0; addr_sel = 1'b0; MARMUX = 16'h4444; Data_from_SRAM = 16'h7777;
    start_m = 1'b1;
    @(negedge Clk);               // SETUP
    start_m = 1'b0;
    @(negedge Clk);               // ACCESS 1
    @(negedge Clk);               // ACCESS 2
    chk("abort_in_access", {31'd0, OE_n}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort_status", {30'd0, busy, done}, 32'd0);
    chk("abort_strobes", {28'd0, CE_n, OE_n, WE_n, data_drive}, 32'b1110);
    chk("abort_mdr", {16'd0, MDR}, 32'd0);
    Reset = 1'b1;
    repeat (6) @(negedge Clk);

    // WAIT_CYCLES=1 instance.
    @(negedge Clk);
    rw = 1'b0; addr_sel = 1'b1; PC = 16'h0ABC; Data_from_SRAM = 16'hC0DE;
    start_1 = 1'b1;
    q_1.push_back('{addr: 16'h0ABC, rw: 1'b0, data: 16'hC0DE, done_cyc: cyc + 3});
    @(negedge Clk);
    start_1 = 1'b0;
    repeat (6) @(negedge Clk);

    // WAIT_CYCLES=15 instance.
    @(negedge Clk);
    rw = 1'b0; addr_sel = 1'b0; MARMUX = 16'hFFFE; Data_from_SRAM = 16'h0F0F;
    start_15 = 1'b1;
    q_15.push_back('{addr: 16'hFFFE, rw: 1'b0, data: 16'h0F0F, done_cyc: cyc + 17});
    @(negedge Clk);
    start_15 = 1'b0;
    repeat (22) @(negedge Clk);

    chk("main_done_count", dones_m, 4);
    chk("w1_done_count", dones_1, 1);
    chk("w15_done_count", dones_15, 1);
    chk("main_queue_drained", q_m.size(), 0);
    chk("w1_queue_drained", q_1.size(), 0);
    chk("w15_queue_drained", q_15.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of SRAM access cycles per transfer; legal range 1..15.
REQ-002 Port: Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  in  1  synchronous, active-low reset.
REQ-004 Port: start  in  1  request strobe from control FSM; sampled only in IDLE.
REQ-005 Port: rw  in  1  0 = read, 1 = write; sampled with start.
REQ-006 Port: addr_sel  in  1  0 = MARMUX, 1 = PC; sampled with start.
REQ-007 Port: MARMUX  in  16  effective address from the address adder.
REQ-008 Port: PC  in  16  program counter, used for instruction fetch.
REQ-009 Port: wdata  in  16  store data; sampled with start when rw=1.
REQ-010 Port: Data_from_SRAM  in  16  SRAM read data.
REQ-011 Port: busy  out  1  high from SETUP through DONE inclusive.
REQ-012 Port: done  out  1  one-cycle completion pulse.
REQ-013 Port: MAR  out  16  latched address register.
REQ-014 Port: MDR  out  16  latched data register; holds read result after a read.
REQ-015 Port: ADDR  out  20  SRAM address = {4'b0000, MAR}.
REQ-016 Port: CE_n, OE_n, WE_n  out  1 each  active-low SRAM strobes.
REQ-017 Port: Data_to_SRAM  out  16  equals MDR.
REQ-018 Port: data_drive  out  1  high when the top level must drive Data_to_SRAM onto the SRAM bus.

Function
REQ-019 FSM states: IDLE, SETUP, ACCESS, DONE.
REQ-020 IDLE->SETUP on start=1. Same edge: MAR <= (addr_sel ? PC : MARMUX), rw latched, and MDR <= wdata if rw=1.
REQ-021 SETUP->ACCESS after exactly one cycle. Wait counter loads WAIT_CYCLES-1.
REQ-022 ACCESS: counter decrements each cycle; ACCESS->DONE when the counter is 0. ACCESS lasts exactly WAIT_CYCLES cycles.
REQ-023 Read: on the final ACCESS edge, MDR <= Data_from_SRAM. MDR is otherwise unchanged.
REQ-024 DONE->IDLE after one cycle. done=1 only in DONE.
REQ-025 Latency: start sampled at edge t gives done high in cycle t+WAIT_CYCLES+2. With WAIT_CYCLES=2, done is high in the 4th cycle after start.
REQ-026 Strobes:
  - CE_n=0 in SETUP and ACCESS.
  - Read: OE_n=0 in SETUP and ACCESS.
  - Write: WE_n=0 in ACCESS only; data_drive=1 in SETUP and ACCESS.
  - All strobes inactive (1) and data_drive=0 in IDLE and DONE.
REQ-027 OE_n and WE_n are never low in the same cycle.
REQ-028 start while busy=1 (including the DONE cycle) is ignored. No queuing.
REQ-029 MAR holds its value from SETUP until the next accepted start. ADDR is stable for the whole transfer.
REQ-030 All outputs are registered or decoded from state only. No combinational path from start to any strobe.

Reset
REQ-031 Reset=0 at a rising edge forces, at that edge: state=IDLE, counter=0, MAR=0, MDR=0, busy=0, done=0, CE_n=OE_n=WE_n=1, data_drive=0.
REQ-032 Reset mid-transfer aborts the transfer, produces no done pulse, and leaves MDR cleared.
REQ-033 Reset has priority over start in the same cycle.

Structure
REQ-034 Package mem_pkg holds the state enum type and the WAIT_CYCLES default constant.
REQ-035 The block is a single module with no sub-module; the wait counter is inline, 4 bits wide.
REQ-036 The block carries an elaboration-time check that rejects WAIT_CYCLES outside 1..15.

Verification
REQ-037 Read, addr_sel=0, MARMUX=16'h3000, SRAM returns 16'hBEEF -> ADDR=20'h03000; OE_n low for 3 cycles; done in cycle t+4; MDR=16'hBEEF.
REQ-038 Write, addr_sel=1, PC=16'h0200, wdata=16'h1234 -> WE_n low exactly 2 cycles; Data_to_SRAM=16'h1234 while data_drive=1; OE_n stays 1.
REQ-039 start held high continuously for 10 cycles -> exactly two transfers (one done every 5 cycles with WAIT_CYCLES=2); no overlap.
REQ-040 Reset=0 during the second ACCESS cycle of a read -> next cycle IDLE, all strobes 1, MDR=0, no done pulse.
REQ-041 WAIT_CYCLES=1 and WAIT_CYCLES=15 -> done in cycles t+3 and t+17 respectively; read data captured correctly in both cases.
